// File: rtl/ov7670_pkg.sv
// Shared types and constants for the OV7670 capture path.
// The OV7670_CAPTURE_GRAY_EN macro is consumed by rgb565_to_pix; nothing here depends on it.
package ov7670_pkg;

    localparam int unsigned COL_BITS = 10;
    localparam int unsigned ROW_BITS = 9;
    localparam int unsigned PIX_BITS = 16;

    // RGB565 field positions: byte 1 = {R[4:0], G[5:3]}, byte 2 = {G[2:0], B[4:0]}
    localparam int unsigned R_MSB = 15;
    localparam int unsigned R_LSB = 11;
    localparam int unsigned G_MSB = 10;
    localparam int unsigned G_LSB = 5;
    localparam int unsigned B_MSB = 4;
    localparam int unsigned B_LSB = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

endpackage

// File: rtl/rgb565_to_pix.sv
// Registered RGB565 -> 8-bit pixel conversion; final pipeline stage before the frame buffer.
// OV7670_CAPTURE_GRAY_EN selects 8-bit luma; otherwise the output is RGB332.
module rgb565_to_pix
    import ov7670_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [PIX_BITS-1:0] pix,
    output logic [7:0]          data
);

    logic [7:0] pix8_c;

`ifdef OV7670_CAPTURE_GRAY_EN
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
    logic [7:0] r8;
    logic [7:0] g8;
    logic [7:0] b8;
    logic [9:0] sum_c;

    assign r = pix[R_MSB:R_LSB];
    assign g = pix[G_MSB:G_LSB];
    assign b = pix[B_MSB:B_LSB];

    // Replicate MSBs so full-scale components map to 255
    assign r8     = {r, r[4:2]};
    assign g8     = {g, g[5:4]};
    assign b8     = {b, b[4:2]};
    assign sum_c  = 10'(r8) + {1'b0, g8, 1'b0} + 10'(b8);
    assign pix8_c = sum_c[9:2];
`else
    logic unused_bits;

    assign pix8_c      = {pix[R_MSB -: 3], pix[G_MSB -: 3], pix[B_MSB -: 2]};
    assign unused_bits = ^{pix[R_LSB+1:R_LSB], pix[G_LSB+2:G_LSB], pix[B_LSB+2:B_LSB]};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
        end else if (load) begin
            data <= pix8_c;
        end
    end

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 capture: VSYNC/HREF framing, RGB565 byte-pair assembly, window crop, raster-order writes.
// Build with OV7670_CAPTURE_GRAY_EN defined for 8-bit luma output instead of RGB332.
module ov7670_capture
    import ov7670_pkg::*;
#(
    parameter int unsigned IMG_W         = 128,
    parameter int unsigned IMG_H         = 128,
    parameter int unsigned X_START       = 256,
    parameter int unsigned Y_START       = 176,
    parameter int unsigned RAM_ADDR_BITS = 14
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     vsync,
    input  logic                     href,
    input  logic [7:0]               din,
    output logic [RAM_ADDR_BITS-1:0] addr_w,
    output logic [7:0]               data_w,
    output logic                     en_w,
    output logic                     frame_done
);

    localparam int unsigned COL_STOP  = X_START + IMG_W;
    localparam int unsigned ROW_END   = Y_START + IMG_H;
    localparam int unsigned LAST_ADDR = IMG_W * IMG_H - 1;
    localparam logic [ROW_BITS-1:0] ROW_MAX = '1;

    logic                vsync_q;
    logic                href_q;
    logic                href_d;
    logic [7:0]          din_q;
    state_t              state;
    state_t              state_nxt;
    logic                frame_start_c;
    logic                in_win_c;
    logic                phase;
    logic [7:0]          hi_q;
    logic [COL_BITS-1:0] col;
    logic [ROW_BITS-1:0] row;
    logic [PIX_BITS-1:0] pix_q;
    logic                wr_q;
    logic                done_q;
    logic                load_c;

    // Input registers; all control below uses these copies
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            href_d  <= 1'b0;
            din_q   <= '0;
        end else begin
            vsync_q <= vsync;
            href_q  <= href;
            href_d  <= href_q;
            din_q   <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        frame_start_c = 1'b0;
        case (state)
            IDLE:    if (vsync_q) state_nxt = SYNC;
            SYNC: begin
                if (!vsync_q) begin
                    state_nxt     = ACTIVE;
                    frame_start_c = 1'b1;
                end
            end
            ACTIVE:  if (vsync_q) state_nxt = SYNC;
            default: state_nxt = IDLE;
        endcase
    end

    assign in_win_c = (32'(row) >= Y_START) && (32'(row) < ROW_END) &&
                      (32'(col) >= X_START) && (32'(col) < COL_STOP);

    // Byte pairing and row/column tracking; a pixel seen together with vsync is dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= 1'b0;
            hi_q  <= '0;
            col   <= '0;
            row   <= '0;
            pix_q <= '0;
            wr_q  <= 1'b0;
        end else begin
            wr_q <= 1'b0;
            if (frame_start_c) begin
                phase <= 1'b0;
                col   <= '0;
                row   <= '0;
            end else if (state == ACTIVE) begin
                if (href_q) begin
                    phase <= ~phase;
                    if (!phase) begin
                        hi_q <= din_q;
                    end else if (!vsync_q) begin
                        pix_q <= {hi_q, din_q};
                        wr_q  <= in_win_c;
                        if (32'(col) < COL_STOP) col <= col + COL_BITS'(1);
                    end
                end else begin
                    phase <= 1'b0;
                    if (href_d) begin
                        col <= '0;
                        if (row != ROW_MAX) row <= row + ROW_BITS'(1);
                    end
                end
            end
        end
    end

    assign load_c = wr_q && !done_q;

    // Write port; address advances on the edge after each strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_w       <= 1'b0;
            addr_w     <= '0;
            frame_done <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            en_w       <= load_c;
            frame_done <= 1'b0;
            if (frame_start_c) begin
                addr_w <= '0;
                done_q <= 1'b0;
            end else if (en_w) begin
                addr_w <= addr_w + RAM_ADDR_BITS'(1);
                if (32'(addr_w) == LAST_ADDR) begin
                    frame_done <= 1'b1;
                    done_q     <= 1'b1;
                end
            end
        end
    end

    rgb565_to_pix u_conv (
        .clk  (clk),
        .rst  (rst),
        .load (load_c),
        .pix  (pix_q),
        .data (data_w)
    );

endmodule

// File: tb/tb_ov7670_capture.sv
// Scoreboard bench for ov7670_capture on a reduced 20x10 frame with an 8x4 window at (5,3).
// Define OV7670_CAPTURE_GRAY_EN for both DUT and bench to check the luma build.
`timescale 1ns/1ps
module tb_ov7670_capture;

    localparam int unsigned IMG_W   = 8;
    localparam int unsigned IMG_H   = 4;
    localparam int unsigned X_START = 5;
    localparam int unsigned Y_START = 3;
    localparam int unsigned AW      = 5;
    localparam int unsigned LAST    = IMG_W * IMG_H - 1;
`ifdef OV7670_CAPTURE_GRAY_EN
    localparam logic [7:0] SPECIAL_EXP = 8'h7F;
`else
    localparam logic [7:0] SPECIAL_EXP = 8'hE3;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          vsync;
    logic          href;
    logic [7:0]    din;
    logic [AW-1:0] addr_w;
    logic [7:0]    data_w;
    logic          en_w;
    logic          frame_done;

    int n_cmp   = 0;
    int n_err   = 0;
    int n_wr    = 0;
    int n_done  = 0;
    int exp_wr  = 0;
    int exp_done = 0;
    logic [AW+7:0] exp_q[$];

    always #5 clk = ~clk;

    ov7670_capture #(
        .IMG_W         (IMG_W),
        .IMG_H         (IMG_H),
        .X_START       (X_START),
        .Y_START       (Y_START),
        .RAM_ADDR_BITS (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .vsync      (vsync),
        .href       (href),
        .din        (din),
        .addr_w     (addr_w),
        .data_w     (data_w),
        .en_w       (en_w),
        .frame_done (frame_done)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_pix(input int r5, input int g6, input int b5);
`ifdef OV7670_CAPTURE_GRAY_EN
        int r8 = (r5 << 3) | (r5 >> 2);
        int g8 = (g6 << 2) | (g6 >> 4);
        int b8 = (b5 << 3) | (b5 >> 2);
        return 8'((r8 + 2 * g8 + b8) / 4);
`else
        return 8'(((r5 >> 2) << 5) | ((g6 >> 3) << 2) | (b5 >> 3));
`endif
    endfunction

    task automatic drive(input logic v, input logic h, input logic [7:0] d);
        @(posedge clk);
        #1;
        vsync = v;
        href  = h;
        din   = d;
    endtask

    // One frame; pixel(c,r) = {r[4:0], c[5:0], 5'h1F} unless (sp_r,sp_c) overrides it with F8 1F
    task automatic send_frame(input int nrows, input int ncols, input int abort_r, input int abort_c,
                              input int odd_r, input int rst_r, input int sp_r, input int sp_c);
        logic [15:0] px;
        logic [7:0]  pe;
        bit          live;
        live = 1'b1;
        repeat (3) drive(1'b1, 1'b0, 8'h00);
        repeat (3) drive(1'b0, 1'b0, 8'h00);
        for (int r = 0; r < nrows; r++) begin
            if (r == rst_r) begin
                @(posedge clk);
                #1 rst = 1'b1;
                repeat (3) @(posedge clk);
                #1 rst = 1'b0;
                @(negedge clk);
                check("rst_addr_w", int'(addr_w), 0);
                check("rst_data_w", int'(data_w), 0);
                check("rst_en_w", int'(en_w), 0);
                check("rst_frame_done", int'(frame_done), 0);
                check("rst_state", int'(dut.state), int'(ov7670_pkg::IDLE));
                live = 1'b0;
            end
            for (int c = 0; c < ncols; c++) begin
                if (r == sp_r && c == sp_c) begin
                    px = 16'hF81F;
                    pe = SPECIAL_EXP;
                end else begin
                    px = {5'(r), 6'(c), 5'h1F};
                    pe = exp_pix(r % 32, c % 64, 31);
                end
                if (r == abort_r && c == abort_c) begin
                    drive(1'b0, 1'b1, px[15:8]);
                    drive(1'b1, 1'b1, px[7:0]);
                    repeat (3) drive(1'b1, 1'b0, 8'h00);
                    return;
                end
                drive(1'b0, 1'b1, px[15:8]);
                drive(1'b0, 1'b1, px[7:0]);
                if (live && r >= int'(Y_START) && r < int'(Y_START + IMG_H) &&
                    c >= int'(X_START) && c < int'(X_START + IMG_W)) begin
                    exp_q.push_back({AW'((r - int'(Y_START)) * int'(IMG_W) + (c - int'(X_START))), pe});
                    exp_wr++;
                end
            end
            if (r == odd_r) drive(1'b0, 1'b1, 8'hA5);
            repeat (4) drive(1'b0, 1'b0, 8'h00);
        end
        if (live) exp_done++;
    endtask

    // Monitor: pops the scoreboard on every write strobe
    initial begin
        logic          prev_en   = 1'b0;
        logic [AW-1:0] prev_addr = '0;
        logic [AW+7:0] e;
        forever begin
            @(negedge clk);
            if (en_w) begin
                n_wr++;
                check("en_w_back_to_back", int'(prev_en), 0);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with nothing expected at %0t",
                             addr_w, data_w, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("addr_w", int'(addr_w), int'(e[AW+7:8]));
                    check("data_w", int'(data_w), int'(e[7:0]));
                end
            end
            if (frame_done) begin
                n_done++;
                check("frame_done_after_last", int'({prev_en, prev_addr}), int'({1'b1, AW'(LAST)}));
            end
            prev_en   = en_w;
            prev_addr = addr_w;
        end
    end

    initial begin
        rst   = 1'b1;
        vsync = 1'b0;
        href  = 1'b0;
        din   = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("init_addr_w", int'(addr_w), 0);
        check("init_data_w", int'(data_w), 0);
        check("init_en_w", int'(en_w), 0);
        check("init_frame_done", int'(frame_done), 0);

        send_frame(10, 20, -1, -1,  4, -1,  4,  6);   // odd line + F8/1F pixel
        send_frame(10, 20,  4,  7, -1, -1, -1, -1);   // vsync with byte 2 of (7,4)
        send_frame(14, 24, -1, -1, -1, -1, -1, -1);   // oversized frame
        send_frame(10, 20, -1, -1, -1,  4, -1, -1);   // reset before row 4
        send_frame(10, 20, -1, -1, -1, -1,  5, 12);   // restart after reset
        repeat (10) drive(1'b0, 1'b0, 8'h00);

        check("pending_expected", exp_q.size(), 0);
        check("write_count", n_wr, exp_wr);
        check("frame_done_count", n_done, exp_done);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
